reg_bank_wr_arbiter: RTL and testbench

//  Shares one bank of NREG x DW registers among NREQ write requesters.

---
 rtl/reg_bank_pkg.sv | 15 +
 rtl/reg_bank_wr_arbiter_rr.sv | 43 ++++
 rtl/reg_bank_wr_arbiter.sv | 88 ++++++++
 tb/tb_reg_bank_wr_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank write arbiter.
// Contents:
//  DW, AW, NREG : default data width, address width and register count
//  idx_w(n)     : width of an index that can address n requesters (at least 1)
package reg_bank_pkg;

  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int NREG = 3;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_bank_wr_arbiter_rr.sv
// Combinational round-robin picker.
// Ports:
//  req  in  NREQ  pending requests
//  ptr  in  IW    highest-priority index for this cycle
//  en   in  1     0 = grant nothing
//  gnt  out NREQ  one-hot grant (or zero)
//  win  out IW    index of the granted requester (0 when none)
//  any  out 1     a grant was issued
module rr_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   win,
  output logic            any
);

  int unsigned idx;

  // NOTE: every output gets a default at the top of the block so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    idx = 0;
    // Scan from ptr upward, wrapping; the first pending request wins.
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !any && req[idx]) begin
        any = 1'b1;
        win = IW'(idx);
      end
    end
    if (any) gnt[win] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_wr_arbiter.sv
// Register bank shared by NREQ write requesters through a round-robin arbiter.
// Ports:
//  clk, rst_n  clock (rising edge), asynchronous active-low reset
//  freeze      1 = issue no grant this cycle
//  req_valid   per-requester write request
//  req_ready   per-requester grant, one-hot or zero, 0 during reset
//  req_addr    requester i register index at [i*AW +: AW]
//  req_data    requester i write data at [i*DW +: DW]
//  q_flat      bank contents, register r at [r*DW +: DW]
//  gnt_valid   a transfer completed on the previous edge
//  gnt_id      index of the most recently granted requester
//  err_addr    previous transfer addressed a register beyond NREG
module reg_bank_wr_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int NREG = reg_bank_pkg::NREG,
  parameter int DW   = reg_bank_pkg::DW,
  parameter int AW   = reg_bank_pkg::AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               freeze,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREG*DW-1:0] q_flat,
  output logic               gnt_valid,
  output logic [2:0]         gnt_id,
  output logic               err_addr
);

  localparam int IW = idx_w(NREQ);

  logic [IW-1:0]           ptr;
  logic [IW-1:0]           win;
  logic                    xfer;
  logic [AW-1:0]           sel_addr;
  logic [DW-1:0]           sel_data;
  logic                    addr_bad;
  logic [NREG-1:0][DW-1:0] q;

  // Gating with rst_n keeps ready low while reset is held, so no handshake
  // can be seen by a requester during reset.
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .en  (rst_n & ~freeze),
    .gnt (req_ready),
    .win (win),
    .any (xfer)
  );

  assign sel_addr = req_addr[int'(win)*AW +: AW];
  assign sel_data = req_data[int'(win)*DW +: DW];
  assign addr_bad = int'(sel_addr) >= NREG;
  assign q_flat   = q;

  // NOTE: the bank is small and its contents must read as zero after reset,
  // so each register is reset like ordinary control state rather than being
  // left as an unreset RAM.
  for (genvar r = 0; r < NREG; r++) begin : g_bank
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              q[r] <= '0;
      else if (xfer && int'(sel_addr) == r)    q[r] <= sel_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      err_addr  <= 1'b0;
    end else begin
      gnt_valid <= xfer;
      err_addr  <= xfer & addr_bad;
      if (xfer) begin
        ptr    <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        gnt_id <= 3'(win);
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Self-checking bench for reg_bank_wr_arbiter (NREQ=3, NREG=3, DW=8, AW=2).
module tb_reg_bank_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [5:0]  req_addr;
  logic [23:0] req_data;
  logic [23:0] q_flat;
  logic        gnt_valid;
  logic [2:0]  gnt_id;
  logic        err_addr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  reg_bank_wr_arbiter #(.NREQ(3), .NREG(3), .DW(8), .AW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .freeze    (freeze),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .q_flat    (q_flat),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .err_addr  (err_addr)
  );

  typedef struct {
    string       name;
    logic        frz;
    logic [2:0]  valid;
    logic [5:0]  addr;
    logic [23:0] data;
    logic [2:0]  exp_ready;
    logic [23:0] exp_q;
    logic        exp_gv;
    logic [2:0]  exp_gid;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input string name, input logic frz, input logic [2:0] valid,
                     input logic [5:0] addr, input logic [23:0] data,
                     input logic [2:0] er, input logic [23:0] eq,
                     input logic egv, input logic [2:0] egid, input logic eerr);
    vec_t v;
    v.name = name; v.frz = frz; v.valid = valid; v.addr = addr; v.data = data;
    v.exp_ready = er; v.exp_q = eq; v.exp_gv = egv; v.exp_gid = egid; v.exp_err = eerr;
    vecs.push_back(v);
  endtask

  initial begin
    // Test 1: reset with every input active.
    rst_n = 1'b0; freeze = 1'b0; req_valid = 3'b111;
    req_addr = 6'h24; req_data = 24'h332211;
    #2;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_q", 32'(q_flat), 32'h0);
    check("rst_gv", 32'(gnt_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_q", 32'(q_flat), 32'h0);
    check("rst_hold_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    req_valid = 3'b000; rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 32'(req_ready), 32'h0);
    check("idle_q", 32'(q_flat), 32'h0);
    check("idle_gv", 32'(gnt_valid), 32'h0);
    check("idle_gid", 32'(gnt_id), 32'h0);
    check("idle_err", 32'(err_addr), 32'h0);

    // Fairness from pointer 0: addr0=0 addr1=1 addr2=2, data 11/22/33.
    add("fair0", 0, 3'b111, 6'h24, 24'h332211, 3'b001, 24'h000011, 1, 0, 0);
    add("fair1", 0, 3'b111, 6'h24, 24'h332211, 3'b010, 24'h002211, 1, 1, 0);
    add("fair2", 0, 3'b111, 6'h24, 24'h332211, 3'b100, 24'h332211, 1, 2, 0);
    add("fair3", 0, 3'b111, 6'h24, 24'h332211, 3'b001, 24'h332211, 1, 0, 0);
    add("fair4", 0, 3'b111, 6'h24, 24'h332211, 3'b010, 24'h332211, 1, 1, 0);
    add("fair5", 0, 3'b111, 6'h24, 24'h332211, 3'b100, 24'h332211, 1, 2, 0);
    // Single write: req0 addr=1 data=A5 (pointer is 0).
    add("single", 0, 3'b001, 6'h01, 24'h0000A5, 3'b001, 24'h33A511, 1, 0, 0);
    add("idle2", 0, 3'b000, 6'h00, 24'h000000, 3'b000, 24'h33A511, 0, 0, 0);
    // Freeze with req0 (addr0 data 99) and req1 (addr2 data 44) pending, ptr=1.
    add("frz0", 1, 3'b011, 6'h08, 24'h004499, 3'b000, 24'h33A511, 0, 0, 0);
    add("frz1", 1, 3'b011, 6'h08, 24'h004499, 3'b000, 24'h33A511, 0, 0, 0);
    add("frz2", 1, 3'b011, 6'h08, 24'h004499, 3'b000, 24'h33A511, 0, 0, 0);
    add("frz3", 1, 3'b011, 6'h08, 24'h004499, 3'b000, 24'h33A511, 0, 0, 0);
    add("unfrz", 0, 3'b011, 6'h08, 24'h004499, 3'b010, 24'h44A511, 1, 1, 0);
    add("after", 0, 3'b001, 6'h08, 24'h004499, 3'b001, 24'h44A599, 1, 0, 0);
    // Bad address: req2 addr=3 data=FF, ptr=1 -> req2 wins, bank unchanged.
    add("badaddr", 0, 3'b100, 6'h30, 24'hFF0000, 3'b100, 24'h44A599, 1, 2, 1);
    add("errdrop", 0, 3'b000, 6'h00, 24'h000000, 3'b000, 24'h44A599, 0, 2, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      freeze = vecs[i].frz; req_valid = vecs[i].valid;
      req_addr = vecs[i].addr; req_data = vecs[i].data;
      #1;
      check({vecs[i].name, "_ready"}, 32'(req_ready), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      check({vecs[i].name, "_q"}, 32'(q_flat), 32'(vecs[i].exp_q));
      check({vecs[i].name, "_gv"}, 32'(gnt_valid), 32'(vecs[i].exp_gv));
      check({vecs[i].name, "_gid"}, 32'(gnt_id), 32'(vecs[i].exp_gid));
      check({vecs[i].name, "_err"}, 32'(err_addr), 32'(vecs[i].exp_err));
    end

    // Move the pointer off 0: req1 alone (addr1, data 6B) -> ptr becomes 2.
    @(negedge clk);
    req_valid = 3'b010; req_addr = 6'h04; req_data = 24'h006B00;
    @(posedge clk); #1;
    check("pre_q", 32'(q_flat), 32'h446B99);

    // Reset during a grant cycle: req0 (addr0 data 5A) and req1 (addr1 data 6B).
    @(negedge clk);
    req_valid = 3'b011; req_addr = 6'h04; req_data = 24'h006B5A;
    #1;
    check("mid_ready_pre", 32'(req_ready), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_ready_rst", 32'(req_ready), 32'h0);
    check("mid_q_rst", 32'(q_flat), 32'h0);
    check("mid_gid_rst", 32'(gnt_id), 32'h0);
    @(posedge clk); #1;
    check("mid_q_edge", 32'(q_flat), 32'h0);
    check("mid_gv_edge", 32'(gnt_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_ready_rel", 32'(req_ready), 32'h1);
    check("mid_q_rel", 32'(q_flat), 32'h0);
    @(posedge clk); #1;
    check("mid_q_wr", 32'(q_flat), 32'h00005A);
    check("mid_gv_wr", 32'(gnt_valid), 32'h1);
    check("mid_gid_wr", 32'(gnt_id), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
